// File: rtl/enum_safe_cast_stream.sv
// Streaming UInt->enum cast: one valid/ready register stage with a legality check against LEGAL_VALS.
// Define ENUM_CAST_STATS_EN to build err_sticky/illegal_cnt/total_cnt; otherwise they are tied to zero.
module enum_safe_cast_stream #(
  parameter int unsigned                  WIDTH      = 7,
  parameter int unsigned                  NUM_VALS   = 5,
  parameter logic [NUM_VALS*WIDTH-1:0]    LEGAL_VALS = {7'd101, 7'd100, 7'd2, 7'd1, 7'd0},
  parameter bit                           STRICT     = 1'b0,
  parameter int unsigned                  CNT_W      = 16,
  localparam int unsigned                 IDX_W      = (NUM_VALS > 1) ? $clog2(NUM_VALS) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_legal,
  output logic [IDX_W-1:0] out_index,
  input  logic             clr_stats,
  output logic             err_sticky,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] total_cnt
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;
  logic             r_legal;
  logic [IDX_W-1:0] r_index;

  logic             w_match;
  logic [IDX_W-1:0] w_index;
  logic             w_accept;
  logic             w_load;

  // Scan from the top entry down so the lowest matching index is the one left standing.
  always_comb begin
    w_match = 1'b0;
    w_index = '0;
    for (int unsigned i = NUM_VALS; i > 0; i--) begin
      if (in_data == LEGAL_VALS[(i-1)*WIDTH +: WIDTH]) begin
        w_match = 1'b1;
        w_index = IDX_W'(i - 1);
      end
    end
  end

  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_load   = w_accept && (w_match || !STRICT);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_legal <= 1'b0;
      r_index <= '0;
    end else if (w_load) begin
      r_valid <= 1'b1;
      r_data  <= in_data;
      r_legal <= w_match;
      r_index <= w_index;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_legal = r_legal;
  assign out_index = r_index;

`ifdef ENUM_CAST_STATS_EN
  logic             r_sticky;
  logic [CNT_W-1:0] r_illegal;
  logic [CNT_W-1:0] r_total;
  logic             w_illegal_acc;

  assign w_illegal_acc = w_accept && !w_match;

  // A clear coinciding with an accepted beat restarts the counts at that beat.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sticky  <= 1'b0;
      r_illegal <= '0;
      r_total   <= '0;
    end else if (clr_stats) begin
      r_sticky  <= w_illegal_acc;
      r_illegal <= CNT_W'(w_illegal_acc);
      r_total   <= CNT_W'(w_accept);
    end else begin
      if (w_illegal_acc)
        r_sticky <= 1'b1;
      if (w_illegal_acc && (r_illegal != '1))
        r_illegal <= r_illegal + CNT_W'(1);
      if (w_accept && (r_total != '1))
        r_total <= r_total + CNT_W'(1);
    end
  end

  assign err_sticky  = r_sticky;
  assign illegal_cnt = r_illegal;
  assign total_cnt   = r_total;
`else
  logic w_unused_clr;
  assign w_unused_clr = clr_stats;
  assign err_sticky   = 1'b0;
  assign illegal_cnt  = '0;
  assign total_cnt    = '0;
`endif

endmodule
